// File: rtl/bpa_mp_add_seq.sv
// Multi-precision add sequencer: drives one external SIZE-bit BPA adder one word
// per cycle, least-significant word first, carrying between words in a register.
module bpa_mp_add_seq #(
    parameter int SIZE  = 16,
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SIZE*WORDS-1:0]   a,
    input  logic [SIZE*WORDS-1:0]   b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [SIZE*WORDS-1:0]   sum,
    output logic                    carry_out,
    output logic [SIZE-1:0]         add_a,
    output logic [SIZE-1:0]         add_b,
    output logic                    add_cin,
    input  logic [SIZE-1:0]         add_sum,
    input  logic                    add_cout
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic [SIZE*WORDS-1:0]   a_q, a_d;
    logic [SIZE*WORDS-1:0]   b_q, b_d;
    logic [SIZE*WORDS-1:0]   sum_q, sum_d;
    logic                    cout_q, cout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The adder is combinational, so its result for this word is written back on the same edge.
                add_a   = a_q[idx_q*SIZE +: SIZE];
                add_b   = b_q[idx_q*SIZE +: SIZE];
                add_cin = carry_q;
                sum_d[idx_q*SIZE +: SIZE] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_bpa_mp_add_seq.sv
// Bench for bpa_mp_add_seq: behavioural BPA adder plus a whole-width arithmetic reference.
module tb_bpa_mp_add_seq;

    localparam int SIZE  = 16;
    localparam int WORDS = 4;
    localparam int W     = SIZE * WORDS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            cin = 1'b0;
    logic            busy, done, carry_out, add_cin, add_cout;
    logic [W-1:0]    sum;
    logic [SIZE-1:0] add_a, add_b, add_sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bpa_mp_add_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Stand-in for the external combinational BPA instance.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SIZE{1'b0}}, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom};
    endfunction

    // Issues one operation from IDLE, checks result/latency, returns at the done cycle.
    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input bit spam, output logic [WORDS-1:0] cins,
                          output int done_cyc);
        logic [W:0] expv;
        int busyc;
        int lat;
        expv  = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
        busyc = 0;
        lat   = 0;
        cins  = '0;
        done_cyc = 0;
        a = oa; b = ob; cin = oc; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            start = 1'b0;
            if (busy) begin
                if (busyc < WORDS) cins[busyc] = add_cin;
                busyc++;
                if (spam && busyc == 2) begin
                    a = rand_w(); b = rand_w(); cin = 1'b1; start = 1'b1;
                end
            end
            if (done) begin
                lat = n;
                done_cyc = cyc;
                if (spam) begin
                    a = rand_w(); b = rand_w(); cin = 1'b0; start = 1'b1;
                end
                break;
            end
        end
        check_eq({tag, " latency"}, (W+1)'(lat), (W+1)'(WORDS + 1));
        check_eq({tag, " busy_cycles"}, (W+1)'(busyc), (W+1)'(WORDS));
        check_eq({tag, " result"}, {carry_out, sum}, expv);
        check_eq({tag, " idle_addr_a"}, (W+1)'(add_a), '0);
    endtask

    initial begin
        logic [WORDS-1:0] cins;
        int dc, prev_dc, ndone;

        tick(); tick();
        rst = 1'b0;
        check_eq("reset busy", (W+1)'(busy), '0);
        check_eq("reset done", (W+1)'(done), '0);
        check_eq("reset result", {carry_out, sum}, '0);
        check_eq("reset add_a", (W+1)'(add_a), '0);
        check_eq("reset add_cin", (W+1)'(add_cin), '0);

        run_op("t1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, cins, dc);
        check_eq("t1 sum", (W+1)'(sum), (W+1)'(64'h0000_0000_0001_0000));
        tick();

        run_op("t2", '1, '0, 1'b1, 1'b0, cins, dc);
        check_eq("t2 add_cin trace", (W+1)'(cins), (W+1)'({WORDS{1'b1}}));
        check_eq("t2 carry_out", (W+1)'(carry_out), (W+1)'(1));
        tick();

        run_op("t3", 64'h1234_5678_9ABC_DEF0, 64'h0101_0101_0101_0101, 1'b0, 1'b0, cins, dc);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t3 hold", {carry_out, sum}, {1'b0, 64'h1335_5779_9BBD_DFF1});
            check_eq("t3 hold busy", (W+1)'(busy), '0);
        end

        run_op("t4", 64'h0000_1111_2222_3333, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, cins, dc);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            if (done) ndone++;
            if (busy) ndone += 100;
        end
        check_eq("t4 ignored starts", (W+1)'(ndone), '0);
        check_eq("t4 result held", {carry_out, sum},
                 {1'b0, 64'h0000_1111_2222_3333} + {1'b0, 64'h0000_0000_FFFF_FFFF} + 65'd1);

        a = rand_w(); b = rand_w(); cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check_eq("t5 busy before reset", (W+1)'(busy), (W+1)'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5 reset result", {carry_out, sum}, '0);
        check_eq("t5 reset busy", (W+1)'(busy), '0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        check_eq("t5 no done", (W+1)'(ndone), '0);
        run_op("t5 fresh", rand_w(), rand_w(), 1'b0, 1'b0, cins, dc);
        tick();

        prev_dc = -1;
        for (int k = 0; k < 100; k++) begin
            run_op("t6", rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'b0, cins, dc);
            if (prev_dc >= 0) check_eq("t6 done spacing", (W+1)'(dc - prev_dc), (W+1)'(WORDS + 2));
            prev_dc = dc;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
